// File: rtl/simmem_pkg.sv
// simmem_pkg: shared stream payload types, state encodings and stub defaults.
package simmem_pkg;
    localparam int IdW            = 4;
    localparam int AddrW          = 32;
    localparam int DataW          = 32;
    localparam int MaxRBurstLenW  = 4;
    localparam int MaxWBurstLenW  = 4;
    localparam int StubRspLatency = 3;
    localparam int StubAddrQDepth = 4;

    typedef struct packed {
        logic [IdW-1:0]           id;
        logic [AddrW-1:0]         addr;
        logic [MaxRBurstLenW-1:0] burst_len;
    } raddr_t;

    typedef struct packed {
        logic [IdW-1:0]           id;
        logic [AddrW-1:0]         addr;
        logic [MaxWBurstLenW-1:0] burst_len;
    } waddr_t;

    typedef struct packed {
        logic [DataW-1:0] data;
    } wdata_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic             last;
    } rdata_t;

    typedef struct packed {
        logic [IdW-1:0] id;
    } wrsp_t;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RSP} w_state_e;
endpackage

// File: rtl/simmem_stub_fifo.sv
// simmem_stub_fifo: small synchronous FIFO; pointer MSB separates full from empty.
module simmem_stub_fifo #(
    parameter type T     = logic,
    parameter int  Depth = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty
);
    localparam int PtrW = $clog2(Depth) + 1;

    logic [PtrW-1:0] r_wptr, r_rptr;
    T r_mem [Depth];

    assign o_empty = r_wptr == r_rptr;
    assign o_full  = (r_wptr[PtrW-1] != r_rptr[PtrW-1]) && (r_wptr[PtrW-2:0] == r_rptr[PtrW-2:0]);
    assign o_data  = r_mem[r_rptr[PtrW-2:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) r_wptr <= r_wptr + PtrW'(1);
            if (i_pop && !o_empty) r_rptr <= r_rptr + PtrW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) r_mem[r_wptr[PtrW-2:0]] <= i_data;
    end
endmodule

// File: rtl/simmem_mem_stub.sv
// simmem_mem_stub: fixed-latency memory stand-in; independent in-order read and write engines.
module simmem_mem_stub
    import simmem_pkg::*;
#(
    parameter int RAddrQDepth = StubAddrQDepth,
    parameter int WAddrQDepth = StubAddrQDepth,
    parameter int RspLatency  = StubRspLatency
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   raddr_valid_i,
    output logic   raddr_ready_o,
    input  raddr_t raddr_i,
    input  logic   waddr_valid_i,
    output logic   waddr_ready_o,
    input  waddr_t waddr_i,
    input  logic   wdata_valid_i,
    output logic   wdata_ready_o,
    input  wdata_t wdata_i,
    output logic   rdata_valid_o,
    input  logic   rdata_ready_i,
    output rdata_t rdata_o,
    output logic   wrsp_valid_o,
    input  logic   wrsp_ready_i,
    output wrsp_t  wrsp_o
);
    localparam int LatW = (RspLatency > 0) ? $clog2(RspLatency + 1) : 1;

    logic   w_rq_full, w_rq_empty, w_rq_pop, w_wq_full, w_wq_empty, w_wq_pop;
    raddr_t w_rq_head;
    waddr_t w_wq_head;
    logic   w_unused;

    simmem_stub_fifo #(.T(raddr_t), .Depth(RAddrQDepth)) u_rq (
        .i_clk(clk_i), .i_rst(rst_i), .i_push(raddr_valid_i && raddr_ready_o), .i_data(raddr_i),
        .o_full(w_rq_full), .i_pop(w_rq_pop), .o_data(w_rq_head), .o_empty(w_rq_empty)
    );

    simmem_stub_fifo #(.T(waddr_t), .Depth(WAddrQDepth)) u_wq (
        .i_clk(clk_i), .i_rst(rst_i), .i_push(waddr_valid_i && waddr_ready_o), .i_data(waddr_i),
        .o_full(w_wq_full), .i_pop(w_wq_pop), .o_data(w_wq_head), .o_empty(w_wq_empty)
    );

    // Addresses and write payload are not modelled; only ids and burst lengths matter.
    assign w_unused = ^{w_rq_head.addr, w_wq_head.addr, wdata_i};

    assign raddr_ready_o = !rst_i && !w_rq_full;
    assign waddr_ready_o = !rst_i && !w_wq_full;

    r_state_e                 r_rstate, w_rstate_nxt;
    logic [IdW-1:0]           r_rid;
    logic [MaxRBurstLenW-1:0] r_rlen;
    logic [MaxRBurstLenW:0]   r_rbeat;
    logic [LatW-1:0]          r_rlat;
    logic                     w_rlast, w_rd_hs;

    assign w_rlast       = r_rbeat == {1'b0, r_rlen};
    assign rdata_valid_o = !rst_i && (r_rstate == R_BURST);
    assign w_rd_hs       = rdata_valid_o && rdata_ready_i;
    assign w_rq_pop      = (r_rstate == R_IDLE) && !w_rq_empty;

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (!w_rq_empty) begin
                         if (RspLatency == 0) w_rstate_nxt = R_BURST;
                         else                 w_rstate_nxt = R_WAIT;
                     end
            R_WAIT:  if (r_rlat == LatW'(1)) w_rstate_nxt = R_BURST;
            R_BURST: if (w_rd_hs && w_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_rlen   <= '0;
            r_rbeat  <= '0;
            r_rlat   <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_rq_pop) begin
                r_rid   <= w_rq_head.id;
                r_rlen  <= w_rq_head.burst_len;
                r_rbeat <= '0;
                r_rlat  <= LatW'(RspLatency);
            end
            if (r_rstate == R_WAIT) r_rlat <= r_rlat - LatW'(1);
            if (w_rd_hs && !w_rlast) r_rbeat <= r_rbeat + 1'b1;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (rdata_valid_o) begin
            rdata_o.id   = r_rid;
            rdata_o.data = DataW'(r_rbeat);
            rdata_o.last = w_rlast;
        end
    end

    w_state_e                 r_wstate, w_wstate_nxt;
    logic [IdW-1:0]           r_wid;
    logic [MaxWBurstLenW-1:0] r_wlen;
    logic [MaxWBurstLenW:0]   r_wbeat;
    logic [LatW-1:0]          r_wlat;
    logic                     w_wlast, w_wd_hs;

    assign w_wlast       = r_wbeat == {1'b0, r_wlen};
    assign wdata_ready_o = !rst_i && (r_wstate == W_DATA);
    assign wrsp_valid_o  = !rst_i && (r_wstate == W_RSP);
    assign w_wd_hs       = wdata_valid_i && wdata_ready_o;
    assign w_wq_pop      = (r_wstate == W_IDLE) && !w_wq_empty;
    assign wrsp_o.id     = wrsp_valid_o ? r_wid : '0;

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (!w_wq_empty) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_wd_hs && w_wlast) begin
                         if (RspLatency == 0) w_wstate_nxt = W_RSP;
                         else                 w_wstate_nxt = W_WAIT;
                     end
            W_WAIT:  if (r_wlat == LatW'(1)) w_wstate_nxt = W_RSP;
            W_RSP:   if (wrsp_ready_i) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wstate <= W_IDLE;
            r_wid    <= '0;
            r_wlen   <= '0;
            r_wbeat  <= '0;
            r_wlat   <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_wq_pop) begin
                r_wid   <= w_wq_head.id;
                r_wlen  <= w_wq_head.burst_len;
                r_wbeat <= '0;
            end
            if (w_wd_hs && !w_wlast) r_wbeat <= r_wbeat + 1'b1;
            if (w_wd_hs && w_wlast) r_wlat <= LatW'(RspLatency);
            if (r_wstate == W_WAIT) r_wlat <= r_wlat - LatW'(1);
        end
    end
endmodule

// File: tb/tb_simmem_mem_stub.sv
// tb_simmem_mem_stub: directed vector table plus hand-written multi-cycle sequences.
module tb_simmem_mem_stub;
    import simmem_pkg::*;

    logic   clk = 0;
    logic   rst;
    logic   raddr_valid, raddr_ready, waddr_valid, waddr_ready, wdata_valid, wdata_ready;
    logic   rdata_valid, rdata_ready, wrsp_valid, wrsp_ready;
    raddr_t raddr;
    waddr_t waddr;
    wdata_t wdata;
    rdata_t rdata;
    wrsp_t  wrsp;

    logic   z_raddr_valid, z_raddr_ready, z_waddr_ready, z_wdata_ready, z_rdata_valid, z_wrsp_valid;
    raddr_t z_raddr;
    rdata_t z_rdata;
    wrsp_t  z_wrsp;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    simmem_mem_stub dut (
        .clk_i(clk), .rst_i(rst),
        .raddr_valid_i(raddr_valid), .raddr_ready_o(raddr_ready), .raddr_i(raddr),
        .waddr_valid_i(waddr_valid), .waddr_ready_o(waddr_ready), .waddr_i(waddr),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
        .wrsp_valid_o(wrsp_valid), .wrsp_ready_i(wrsp_ready), .wrsp_o(wrsp)
    );

    simmem_mem_stub #(.RspLatency(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .raddr_valid_i(z_raddr_valid), .raddr_ready_o(z_raddr_ready), .raddr_i(z_raddr),
        .waddr_valid_i(1'b0), .waddr_ready_o(z_waddr_ready), .waddr_i('0),
        .wdata_valid_i(1'b0), .wdata_ready_o(z_wdata_ready), .wdata_i('0),
        .rdata_valid_o(z_rdata_valid), .rdata_ready_i(1'b1), .rdata_o(z_rdata),
        .wrsp_valid_o(z_wrsp_valid), .wrsp_ready_i(1'b1), .wrsp_o(z_wrsp)
    );

    typedef struct {
        logic        av;
        logic [3:0]  aid;
        logic [3:0]  alen;
        logic        rdy;
        logic        ev;
        logic [3:0]  eid;
        logic [31:0] edat;
        logic        el;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic av, logic [3:0] aid, logic [3:0] alen, logic rdy,
                                logic ev, logic [3:0] eid, logic [31:0] edat, logic el);
        vec_t v;
        v.av = av; v.aid = aid; v.alen = alen; v.rdy = rdy;
        v.ev = ev; v.eid = eid; v.edat = edat; v.el = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [3:0] id, input logic [3:0] len);
        raddr.id = id;
        raddr.burst_len = len;
    endtask

    task automatic set_wa(input logic [3:0] id, input logic [3:0] len);
        waddr.id = id;
        waddr.burst_len = len;
    endtask

    initial begin
        int got;
        int stale;
        rst = 1;
        raddr_valid = 0; waddr_valid = 0; wdata_valid = 0;
        rdata_ready = 0; wrsp_ready = 1;
        raddr = '0; waddr = '0; wdata = '0;
        z_raddr_valid = 0; z_raddr = '0;

        // Reset behaviour
        repeat (2) tick;
        @(negedge clk);
        chk("rst_raddr_ready", raddr_ready, 0);
        chk("rst_waddr_ready", waddr_ready, 0);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_wrsp_valid", wrsp_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_wrsp", wrsp, 0);
        chk("rst_z_raddr_ready", z_raddr_ready, 0);
        tick;
        rst = 0;
        @(negedge clk);
        chk("post_rst_raddr_ready", raddr_ready, 1);
        chk("post_rst_waddr_ready", waddr_ready, 1);

        // Table: basic 4-beat read, then 8-beat read with alternating stalls
        vecs.push_back(mk(1, 2, 3, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        for (int b = 0; b < 4; b++) vecs.push_back(mk(0, 0, 0, 1, 1, 2, b, b == 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int b = 0; b < 8; b++) begin
            vecs.push_back(mk(0, 0, 0, 0, 1, 1, b, b == 7));
            vecs.push_back(mk(0, 0, 0, 1, 1, 1, b, b == 7));
        end
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        foreach (vecs[i]) begin
            tick;
            raddr_valid = vecs[i].av;
            set_ra(vecs[i].aid, vecs[i].alen);
            rdata_ready = vecs[i].rdy;
            @(negedge clk);
            if (vecs[i].av) chk($sformatf("v%0d_raddr_ready", i), raddr_ready, 1);
            chk($sformatf("v%0d_rvalid", i), rdata_valid, vecs[i].ev);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_rid", i), rdata.id, vecs[i].eid);
                chk($sformatf("v%0d_rdata", i), rdata.data, vecs[i].edat);
                chk($sformatf("v%0d_rlast", i), rdata.last, vecs[i].el);
            end
        end
        tick;
        raddr_valid = 0;
        rdata_ready = 0;

        // Write: data arrives early and is stalled until the address is in
        wdata_valid = 1;
        for (int k = 0; k < 5; k++) begin
            tick;
            @(negedge clk);
            chk("w_early_wready", wdata_ready, 0);
        end
        tick; waddr_valid = 1; set_wa(5, 1);
        @(negedge clk); chk("w_waddr_ready", waddr_ready, 1);
        tick; waddr_valid = 0;
        @(negedge clk); chk("w_t1_wready", wdata_ready, 0);
        tick; @(negedge clk); chk("w_t2_wready", wdata_ready, 1);
        tick; @(negedge clk); chk("w_t3_wready", wdata_ready, 1);
        tick; wdata_valid = 0;
        @(negedge clk); chk("w_t4_wready", wdata_ready, 0); chk("w_t4_wrsp", wrsp_valid, 0);
        tick; @(negedge clk); chk("w_t5_wrsp", wrsp_valid, 0);
        tick; @(negedge clk); chk("w_t6_wrsp", wrsp_valid, 0);
        tick; wrsp_ready = 0;
        @(negedge clk); chk("w_t7_wrsp", wrsp_valid, 1); chk("w_t7_id", wrsp.id, 5);
        tick; wrsp_ready = 1;
        @(negedge clk); chk("w_t8_wrsp_hold", wrsp_valid, 1); chk("w_t8_id", wrsp.id, 5);
        tick; @(negedge clk); chk("w_t9_wrsp", wrsp_valid, 0);

        // Queue fill: one burst latched plus four queued fills the read queue
        rdata_ready = 0;
        for (int k = 0; k < 5; k++) begin
            tick; raddr_valid = 1; set_ra(4'(3 + k), 1);
            @(negedge clk); chk($sformatf("q_accept%0d", k), raddr_ready, 1);
        end
        tick; raddr_valid = 0;
        @(negedge clk); chk("q_full_ready", raddr_ready, 0);
        repeat (6) tick;
        @(negedge clk); chk("q_full_hold", raddr_ready, 0);
        tick; rdata_ready = 1;
        got = 0;
        for (int k = 0; k < 200 && got < 10; k++) begin
            @(negedge clk);
            if (rdata_valid) begin
                chk($sformatf("q_beat%0d_id", got), rdata.id, 3 + got / 2);
                chk($sformatf("q_beat%0d_data", got), rdata.data, got % 2);
                chk($sformatf("q_beat%0d_last", got), rdata.last, got % 2);
                got++;
            end
            tick;
        end
        chk("q_drain_count", got, 10);
        rdata_ready = 0;

        // Zero latency: back-to-back single-beat reads
        tick; z_raddr_valid = 1; z_raddr.id = 1; z_raddr.burst_len = 0;
        @(negedge clk); chk("z_accept1", z_raddr_ready, 1);
        tick; z_raddr.id = 2;
        @(negedge clk); chk("z_t1_valid", z_rdata_valid, 0);
        tick; z_raddr_valid = 0;
        @(negedge clk); chk("z_t2_valid", z_rdata_valid, 1); chk("z_t2_id", z_rdata.id, 1);
        chk("z_t2_last", z_rdata.last, 1);
        tick; @(negedge clk); chk("z_t3_valid", z_rdata_valid, 0);
        tick; @(negedge clk); chk("z_t4_valid", z_rdata_valid, 1); chk("z_t4_id", z_rdata.id, 2);
        tick; @(negedge clk); chk("z_t5_valid", z_rdata_valid, 0);

        // Reset in the middle of a read burst with a write pending its response
        for (int k = 0; k < 8; k++) begin
            tick;
            raddr_valid = (k < 2);
            set_ra((k == 0) ? 4'd6 : 4'd7, (k == 0) ? 4'd3 : 4'd0);
            waddr_valid = (k == 4 || k == 5);
            set_wa((k == 4) ? 4'd4 : 4'd9, 0);
            wdata_valid = (k >= 4);
            rdata_ready = 1;
            @(negedge clk);
        end
        chk("r_mid_valid", rdata_valid, 1);
        chk("r_mid_data", rdata.data, 2);
        rst = 1;
        raddr_valid = 0; waddr_valid = 0; wdata_valid = 0;
        #1;
        chk("r_asrt_rvalid", rdata_valid, 0);
        chk("r_asrt_rready", raddr_ready, 0);
        tick; @(negedge clk);
        chk("r_next_rvalid", rdata_valid, 0);
        chk("r_next_wrsp", wrsp_valid, 0);
        chk("r_next_raddr_ready", raddr_ready, 0);
        chk("r_next_waddr_ready", waddr_ready, 0);
        tick; rst = 0;
        @(negedge clk);
        chk("r_rel_raddr_ready", raddr_ready, 1);
        chk("r_rel_waddr_ready", waddr_ready, 1);
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            tick; @(negedge clk);
            if (rdata_valid || wrsp_valid || wdata_ready) stale++;
        end
        chk("r_no_stale", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
